// File: rtl/ram_master.sv
// Synchronous master for an asynchronous single-port RAM with a shared tristate data bus.
// All RAM-side pins are registered from the next-state decode so we/drive-enable never skew.
module ram_master #(
  parameter int ADDR_W          = 10,
  parameter int DATA_W          = 16,
  parameter int WR_PULSE_CYCLES = 2,
  parameter int RD_WAIT_CYCLES  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_address,
  inout  wire  [DATA_W-1:0] ram_data
);

  localparam int CNT_MAX = (WR_PULSE_CYCLES > RD_WAIT_CYCLES) ? WR_PULSE_CYCLES : RD_WAIT_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_WAIT, RD_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] wdata_q;
  logic              drv_en;

  // Master only ever drives the bus while the RAM is in write mode.
  assign ram_data = drv_en ? wdata_q : 'z;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = wr ? WR_SETUP : RD_WAIT;
        if (!wr) cnt_d = CW'(RD_WAIT_CYCLES - 1);
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = CW'(WR_PULSE_CYCLES - 1);
      end
      WR_PULSE: if (cnt_q == '0) state_d = WR_HOLD;
                else cnt_d = cnt_q - CW'(1);
      WR_HOLD:  state_d = IDLE;
      RD_WAIT:  if (cnt_q == '0) state_d = RD_DONE;
                else cnt_d = cnt_q - CW'(1);
      RD_DONE:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready       <= 1'b1;
      done        <= 1'b0;
      rdata       <= '0;
      ram_we      <= 1'b1;
      drv_en      <= 1'b0;
      ram_address <= '0;
      wdata_q     <= '0;
    end else begin
      ready  <= (state_d == IDLE);
      done   <= (state_d == WR_HOLD) || (state_d == RD_DONE);
      // we and drive enable come from one decode, so they change on the same edge
      ram_we <= (state_d != WR_PULSE);
      drv_en <= (state_d == WR_PULSE);
      if (state_q == IDLE && req) begin
        ram_address <= addr;
        wdata_q     <= wdata;
      end
      if (state_q == RD_WAIT && cnt_q == '0) rdata <= ram_data;
    end
  end

endmodule

// File: doc/ram_master.md
# ram_master

Synchronous bus master that drives the asynchronous 1K×16 single-port RAM through its `we`/`address`/`data` interface. Host logic issues single read/write requests over a req/ready handshake, and the block sequences the RAM pins safely. RAM `we` is active-low write and active-high read, and the RAM drives `data` whenever `we` is high. The block therefore guarantees it never drives `ram_data` while `ram_we` is high. It sits between the datapath/control unit and the RAM instance.

## Interface
Parameters:
- `ADDR_W`, 10, RAM address width.
- `DATA_W`, 16, RAM data width.
- `WR_PULSE_CYCLES`, 2, cycles `ram_we` is held low per write (≥1).
- `RD_WAIT_CYCLES`, 1, cycles the address is held before read data is captured (≥1).

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 1: host request; accepted when `req && ready` at a rising edge.
- `wr` in 1: 1 = write, 0 = read; sampled at accept.
- `addr` in ADDR_W: transaction address; sampled at accept.
- `wdata` in DATA_W: write data; sampled at accept.
- `ready` out 1: block is idle and can accept a request.
- `done` out 1: one-cycle pulse marking transaction completion.
- `rdata` out DATA_W: last read result; valid with `done` for reads and held until the next read completes.
- `ram_we` out 1: RAM write enable (0 = write, 1 = read).
- `ram_address` out ADDR_W: RAM address.
- `ram_data` inout DATA_W: RAM data bus; driven only while `ram_we` = 0, otherwise high-Z.

## Operation
- States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_WAIT, RD_DONE.
- All RAM-side outputs and the bus-drive enable are registered. There is no combinational path from host inputs to RAM pins.
- **IDLE**
  - `ready` = 1, `ram_we` = 1, bus high-Z.
  - `ram_address` holds its last value.
  - On accept: latch `addr`, `wdata` and `wr`. Go to WR_SETUP if `wr` = 1, else RD_WAIT.
- **WR_SETUP** (1 cycle)
  - `ram_address` = latched address, `ram_we` = 1, bus high-Z.
  - Next state: WR_PULSE.
- **WR_PULSE** (WR_PULSE_CYCLES cycles, down-counter)
  - `ram_we` = 0; `ram_data` driven with the latched wdata.
  - Address is stable throughout.
  - Next state: WR_HOLD.
- **WR_HOLD** (1 cycle)
  - `ram_we` = 1, bus released in the same edge as `ram_we` rising.
  - Address still held; `done` = 1.
  - Next state: IDLE.
- **RD_WAIT** (RD_WAIT_CYCLES cycles)
  - `ram_address` = latched address, `ram_we` = 1, bus high-Z.
  - On the final cycle's edge, `rdata` <= `ram_data`.
  - Next state: RD_DONE.
- **RD_DONE** (1 cycle)
  - `done` = 1 and `rdata` valid.
  - Next state: IDLE.
- `req` outside IDLE is ignored, not queued. Host inputs may change freely after accept.
- `ready` = (state == IDLE). `done` is never high in IDLE.

## Timing
- Reset values (asynchronous):
  - state IDLE, `ready` = 1, `done` = 0, `rdata` = 0.
  - `ram_we` = 1, `ram_address` = 0, bus high-Z, counter 0.
- Write latency:
  - Accept edge at cycle 0.
  - WR_SETUP in cycle 1.
  - `ram_we` low in cycles 2..WR_PULSE_CYCLES+1.
  - `done` in cycle WR_PULSE_CYCLES+2; `ready` again the following cycle.
  - Default: done in cycle 4, next accept possible at the end of cycle 5.
- Read latency:
  - Address valid from cycle 1.
  - Capture at the end of cycle RD_WAIT_CYCLES; `done` with `rdata` in cycle RD_WAIT_CYCLES+1.
  - Default: done in cycle 2.
- Back-to-back: `req` held high is accepted at the first edge where `ready` = 1. There is no dead cycle beyond the IDLE cycle.
- Bus safety:
  - `ram_data` drive enable is 1 only in WR_PULSE.
  - `ram_we` and the drive enable switch on the same edge from the same state decode.
- Reset mid-write: `ram_we` returns to 1 and the bus releases immediately. A partially written word is permitted. No `done` is issued.
- Reset mid-read: `rdata` is cleared to 0 and no `done` is issued.
- Address wrap: addresses are not incremented, so no wrap logic. 10'h3FF is a legal address.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-WR_PULSE → `ram_we` = 1 and `ram_data` = Z within the same timestep; `ready` = 1, `done` = 0, `rdata` = 0.
- **Write:** write 16'hA5C3 to 10'h012 → `ram_we` low for exactly 2 cycles with `ram_data` = A5C3 and `ram_address` = 012; `done` pulses 4 cycles after accept. RAM word 012 = A5C3.
- **Read:** read 10'h012 after that write → `done` 2 cycles after accept with `rdata` = 16'hA5C3. Bus never driven by the master.
- **Address boundaries:** write 16'hFFFF to 10'h3FF, then 16'h0001 to 10'h000, then read both → 16'hFFFF and 16'h0001. An unwritten address, e.g. 10'h200, reads 16'h0000.
- **Ignored request:** pulse `req` during WR_PULSE → ignored: no second transaction and `done` count = 1. Hold `req` high continuously for 3 reads → 3 `done` pulses, each preceded by exactly one `ready` cycle.
- **Bus-contention checker:** assertion over all tests that `ram_data` is never driven by the master while `ram_we` = 1. Rerun all tests with WR_PULSE_CYCLES = 1 and RD_WAIT_CYCLES = 3; latencies scale as specified.
